// File: rtl/extclk_pkg.sv
// Shared definitions for the external-clock sequencing controller:
// FSM state codes, default timing parameters and a sizing helper.
package extclk_pkg;

  typedef enum logic [2:0] {
    ST_NOSIG    = 3'd0,
    ST_DCMRST   = 3'd1,
    ST_WAITLOCK = 3'd2,
    ST_ZERO     = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  localparam int WATCH_DEF    = 64;
  localparam int RST_LEN_DEF  = 16;
  localparam int LOCK_TMO_DEF = 4096;
  localparam int ZERO_LEN_DEF = 8;

  localparam logic [7:0] FAIL_MAX = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tog_watch.sv
// Activity detector for the divided external toggle: 2-flop synchronizer,
// change detect, and a watch window that expires when toggles stop.
module tog_watch
  import extclk_pkg::*;
#(
  parameter int WATCH = WATCH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tog,
  output logic act
);

  localparam int AW = $clog2(WATCH + 1);

  // sync[0] and sync[1] form the synchronizer, sync[2] holds the previous value
  logic [2:0]    sync;
  logic [AW-1:0] act_cnt;
  logic          tog_edge;

  assign tog_edge = sync[1] ^ sync[2];
  assign act      = (act_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      act_cnt <= '0;
    end else begin
      sync <= {sync[1:0], tog};
      if (tog_edge)
        act_cnt <= AW'(WATCH - 1);
      else if (act_cnt != '0)
        act_cnt <= act_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/extclk_ctrl.sv
// Sequencer that brings up the external clock path: waits for activity,
// resets the DCM, waits for lock, zeroes the external counter, then runs.
//   state    | meaning
//   NOSIG    | no external activity, everything held in reset
//   DCMRST   | DCM reset pulse of RST_LEN cycles
//   WAITLOCK | DCM released, waiting up to LOCK_TMO cycles for lock
//   ZERO     | external counter reset pulse of ZERO_LEN cycles
//   RUN      | external clock valid, counter running
module extclk_ctrl
  import extclk_pkg::*;
#(
  parameter int WATCH    = WATCH_DEF,
  parameter int RST_LEN  = RST_LEN_DEF,
  parameter int LOCK_TMO = LOCK_TMO_DEF,
  parameter int ZERO_LEN = ZERO_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_tog,
  input  logic       dcm_locked,
  input  logic       sync_req,
  output logic       dcmreset,
  output logic       cnt_reset,
  output logic       cnt_inhibit,
  output logic       ext_ok,
  output logic       sync_ack,
  output logic [2:0] state,
  output logic [7:0] fail_cnt
);

  localparam int TW = $clog2(max3(RST_LEN, LOCK_TMO, ZERO_LEN) + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    lock_sync;
  logic          locked;
  logic          act;
  logic          ack_d, fail_inc;
  logic          dcmreset_d, cnt_reset_d, cnt_inhibit_d, ext_ok_d;

  tog_watch #(.WATCH(WATCH)) u_tog_watch (
    .clk   (clk),
    .reset (reset),
    .tog   (ext_tog),
    .act   (act)
  );

  assign locked = lock_sync[1];
  assign state  = state_q;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    fail_inc = 1'b0;
    case (state_q)
      ST_NOSIG: begin
        if (act) state_d = ST_DCMRST;
      end
      ST_DCMRST: begin
        if (!act)                state_d = ST_NOSIG;
        else if (timer_q == '0)  state_d = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        if (!act)               state_d = ST_NOSIG;
        else if (locked)        state_d = ST_ZERO;
        else if (timer_q == '0) begin
          state_d  = ST_DCMRST;
          fail_inc = 1'b1;
        end
      end
      ST_ZERO: begin
        if (timer_q == '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        // loss of signal wins over a pending re-zero request
        if (!act || !locked) state_d = ST_NOSIG;
        else if (sync_req) begin
          state_d = ST_ZERO;
          ack_d   = 1'b1;
        end
      end
      default: state_d = ST_NOSIG;
    endcase
  end

  // One timer serves every timed state; it is reloaded on each state entry.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_DCMRST:   timer_d = TW'(RST_LEN - 1);
        ST_WAITLOCK: timer_d = TW'(LOCK_TMO - 1);
        ST_ZERO:     timer_d = TW'(ZERO_LEN - 1);
        default:     timer_d = '0;
      endcase
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_comb begin
    dcmreset_d    = (state_d == ST_NOSIG) || (state_d == ST_DCMRST);
    cnt_reset_d   = (state_d == ST_NOSIG) || (state_d == ST_ZERO);
    cnt_inhibit_d = (state_d != ST_RUN);
    ext_ok_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_NOSIG;
      timer_q     <= '0;
      lock_sync   <= '0;
      fail_cnt    <= '0;
      dcmreset    <= 1'b1;
      cnt_reset   <= 1'b1;
      cnt_inhibit <= 1'b1;
      ext_ok      <= 1'b0;
      sync_ack    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lock_sync   <= {lock_sync[0], dcm_locked};
      dcmreset    <= dcmreset_d;
      cnt_reset   <= cnt_reset_d;
      cnt_inhibit <= cnt_inhibit_d;
      ext_ok      <= ext_ok_d;
      sync_ack    <= ack_d;
      if (fail_inc && (fail_cnt != FAIL_MAX))
        fail_cnt <= fail_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_extclk_ctrl.sv
// Directed bench for extclk_ctrl: state-segment scoreboard plus timing checks
// for bring-up, re-zero, signal loss, lock timeouts and mid-sequence reset.
module tb_extclk_ctrl;

  localparam int WATCH    = 64;
  localparam int RST_LEN  = 16;
  localparam int LOCK_TMO = 128;
  localparam int ZERO_LEN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ext_tog = 1'b0;
  logic       dcm_locked = 1'b0;
  logic       sync_req = 1'b0;
  logic       dcmreset, cnt_reset, cnt_inhibit, ext_ok, sync_ack;
  logic [2:0] state;
  logic [7:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tog = 0;
  bit tog_en = 1'b0;

  typedef struct {
    int st;
    int len;
  } seg_t;

  seg_t exp_q[$];
  seg_t obs_q[$];
  logic [2:0] mon_st = 3'bxxx;
  int mon_len = 0;

  extclk_ctrl #(
    .WATCH    (WATCH),
    .RST_LEN  (RST_LEN),
    .LOCK_TMO (LOCK_TMO),
    .ZERO_LEN (ZERO_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ext_tog     (ext_tog),
    .dcm_locked  (dcm_locked),
    .sync_req    (sync_req),
    .dcmreset    (dcmreset),
    .cnt_reset   (cnt_reset),
    .cnt_inhibit (cnt_inhibit),
    .ext_ok      (ext_ok),
    .sync_ack    (sync_ack),
    .state       (state),
    .fail_cnt    (fail_cnt)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external toggle source, one change every 8 clk cycles while enabled
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        div++;
        if (div == 8) begin
          div = 0;
          ext_tog = ~ext_tog;
          last_tog = cyc;
        end
      end else begin
        div = 0;
      end
    end
  end

  // state-segment monitor: logs (state, cycles held) when the state changes
  initial begin
    seg_t s;
    forever begin
      @(negedge clk);
      if (state !== mon_st) begin
        if (mon_len > 0) begin
          s.st  = int'(mon_st);
          s.len = mon_len;
          obs_q.push_back(s);
        end
        mon_st  = state;
        mon_len = 1;
      end else begin
        mon_len++;
      end
    end
  end

  initial begin
    #(8 * 200000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_st(input logic [2:0] s, input int maxc, input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (state === s) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic push_exp(input int st, input int len);
    seg_t s;
    s.st  = st;
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic sb_pop(input string tag);
    seg_t e, o;
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (obs_q.size() > 0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_avail"}, 32'(got), 32'd1);
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_state"}, o.st, e.st);
      if (e.len >= 0) chk({tag, "_len"}, o.len, e.len);
    end
  endtask

  initial begin
    int zc, t_prev, period;
    bit ack_seen;

    // reset state
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_dcmreset", dcmreset, 1);
    chk("rst_cnt_reset", cnt_reset, 1);
    chk("rst_cnt_inhibit", cnt_inhibit, 1);
    chk("rst_ext_ok", ext_ok, 0);
    chk("rst_sync_ack", sync_ack, 0);
    chk("rst_fail_cnt", fail_cnt, 0);

    // bring-up
    obs_q.delete();
    push_exp(0, -1);
    push_exp(1, RST_LEN);
    push_exp(2, -1);
    push_exp(3, ZERO_LEN);
    @(posedge clk); #1;
    reset  = 1'b0;
    tog_en = 1'b1;
    wait_st(2, 200, "reach_waitlock");
    chk("wl_dcmreset", dcmreset, 0);
    chk("wl_cnt_inhibit", cnt_inhibit, 1);

    // re-zero request outside RUN is dropped
    @(posedge clk); #1 sync_req = 1'b1;
    @(posedge clk); #1 sync_req = 1'b0;
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ack_seen |= sync_ack;
    end
    chk("wl_no_ack", 32'(ack_seen), 0);
    chk("wl_hold", state, 2);

    repeat (94) @(posedge clk);
    #1 dcm_locked = 1'b1;
    wait_st(4, 200, "reach_run");
    chk("run_ext_ok", ext_ok, 1);
    chk("run_cnt_inhibit", cnt_inhibit, 0);
    chk("run_dcmreset", dcmreset, 0);
    chk("run_cnt_reset", cnt_reset, 0);
    repeat (4) sb_pop("bringup");

    // re-zero from RUN
    obs_q.delete();
    exp_q.delete();
    push_exp(4, -1);
    push_exp(3, ZERO_LEN);
    @(posedge clk); #1 sync_req = 1'b1;
    @(posedge clk); #1 sync_req = 1'b0;
    @(negedge clk);
    chk("sync_ack_pulse", sync_ack, 1);
    chk("sync_to_zero", state, 3);
    zc = 1;
    ack_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ack_seen |= sync_ack;
      if (cnt_reset) zc++;
      else break;
    end
    chk("zero_len", zc, ZERO_LEN);
    chk("ack_single", 32'(ack_seen), 0);
    chk("rerun_state", state, 4);
    repeat (2) sb_pop("resync");

    // request in the same cycle the synchronized lock drops
    @(posedge clk); #1 dcm_locked = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 sync_req = 1'b1;
    @(posedge clk); #1 sync_req = 1'b0;
    @(negedge clk);
    chk("lockdrop_state", state, 0);
    chk("lockdrop_no_ack", sync_ack, 0);
    chk("lockdrop_ext_ok", ext_ok, 0);

    // recover, then stop the toggle
    dcm_locked = 1'b1;
    wait_st(4, 400, "rerun2");
    tog_en = 1'b0;
    wait_st(0, WATCH + 20, "sig_loss");
    chk("loss_latency", cyc - last_tog, WATCH + 3);
    chk("loss_ext_ok", ext_ok, 0);
    chk("loss_cnt_inhibit", cnt_inhibit, 1);
    chk("loss_dcmreset", dcmreset, 1);

    // lock never arrives: repeated timeouts, counter saturates
    dcm_locked = 1'b0;
    tog_en     = 1'b1;
    wait_st(1, 100, "to_first_rst");
    chk("to_fail_init", fail_cnt, 0);
    t_prev = cyc;
    for (int i = 1; i <= 300; i++) begin
      wait_st(2, RST_LEN + 5, "to_waitlock");
      wait_st(1, LOCK_TMO + 5, "to_dcmrst");
      period = cyc - t_prev;
      t_prev = cyc;
      chk("to_period", period, RST_LEN + LOCK_TMO);
      chk("to_fail_cnt", fail_cnt, (i > 255) ? 255 : i);
      chk("to_dcmreset", dcmreset, 1);
    end

    // reset in WAITLOCK
    wait_st(2, RST_LEN + 5, "pre_rst_wl");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_wl", {state, dcmreset, cnt_reset, cnt_inhibit, ext_ok, sync_ack, fail_cnt},
        {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

    // reset in ZERO
    @(posedge clk); #1;
    reset      = 1'b0;
    dcm_locked = 1'b1;
    wait_st(3, 200, "pre_rst_zero");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_zero", {state, dcmreset, cnt_reset, cnt_inhibit, ext_ok, sync_ack, fail_cnt},
        {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/extclk_ctrl.md
EXTCLK_CTRL -- requirements
Module: extclk_ctrl

Interface
REQ-001 Parameter WATCH, default 64: activity window in clk cycles; input toggle must be seen at least once per window.
REQ-002 Parameter RST_LEN, default 16: dcmreset pulse length in clk cycles.
REQ-003 Parameter LOCK_TMO, default 4096: cycles allowed for dcm_locked after dcmreset release.
REQ-004 Parameter ZERO_LEN, default 8: cnt_reset pulse length; must be at least 4 so the external-frequency domain latches it.
REQ-005 Ports (clk first, then reset):
- clk  in  1  system clock, 125 MHz.
- reset  in  1  synchronous, active-high reset.
- ext_tog  in  1  asynchronous divided toggle from the external-frequency domain.
- dcm_locked  in  1  asynchronous DCM lock status.
- sync_req  in  1  single-cycle request to re-zero the external counter.
- dcmreset  out  1  DCM reset.
- cnt_reset  out  1  external counter reset.
- cnt_inhibit  out  1  external counter inhibit.
- ext_ok  out  1  external clock valid and counting.
- sync_ack  out  1  single-cycle acknowledge of sync_req.
- state  out  3  current FSM state code.
- fail_cnt  out  8  count of lock timeouts, saturating.

Function
REQ-006 ext_tog and dcm_locked shall each pass a 2-flop synchronizer before use; an ext_tog edge is any change of the synchronized value.
REQ-007 An activity counter shall reload to WATCH-1 on every ext_tog edge and decrement otherwise; act = counter nonzero; counter stops at 0.
REQ-008 The FSM shall have states NOSIG=0, DCMRST=1, WAITLOCK=2, ZERO=3, RUN=4.
REQ-009 NOSIG: dcmreset=1, cnt_reset=1, cnt_inhibit=1; on act=1 go to DCMRST.
REQ-010 DCMRST: dcmreset=1 and cnt_inhibit=1 for exactly RST_LEN cycles, then go to WAITLOCK; on act=0 go to NOSIG.
REQ-011 WAITLOCK: dcmreset=0 and cnt_inhibit=1; on synchronized dcm_locked=1 go to ZERO.
REQ-012 In WAITLOCK, after LOCK_TMO cycles without lock, go to DCMRST and increment fail_cnt, saturating at 255.
REQ-013 In WAITLOCK, act=0 shall go to NOSIG and takes priority over lock and timeout.
REQ-014 ZERO: cnt_reset=1 and cnt_inhibit=1 for exactly ZERO_LEN cycles, then go to RUN.
REQ-015 RUN: ext_ok=1 with all other control outputs 0.
REQ-016 In RUN, act=0 or dcm_locked=0 shall go to NOSIG on the next cycle.
REQ-017 In RUN, sync_req=1 shall go to ZERO and pulse sync_ack for one cycle in the same transition cycle; loss of signal has priority and suppresses sync_ack.
REQ-018 sync_req in any state other than RUN shall be ignored, with no ack and no queuing.
REQ-019 ext_ok shall be registered and shall be 1 only in RUN.
REQ-020 All outputs shall be registered and driven from state and timers, with no combinational path from inputs.
REQ-021 A single shared timer shall be loaded on each state entry and sized to cover max(RST_LEN, LOCK_TMO, ZERO_LEN).

Reset
REQ-022 On reset=1 the FSM shall enter NOSIG: dcmreset=1, cnt_reset=1, cnt_inhibit=1, ext_ok=0, sync_ack=0, fail_cnt=0, activity counter=0, synchronizers=0.
REQ-023 Reset mid-sequence, in any state, shall abort to NOSIG on the next clk edge.

Structure
REQ-024 State encodings and default parameter values shall live in shared package extclk_pkg.
REQ-025 The activity detector (synchronizer, edge detect, window counter) shall be the sub-module tog_watch, outputting act.

Verification
REQ-026 Reset released, ext_tog toggling every 8 cycles, dcm_locked rising 100 cycles after dcmreset falls -> dcmreset high 16 cycles, cnt_reset high 8 cycles, then ext_ok=1 and state=4.
REQ-027 dcm_locked never asserts -> fail_cnt increments every 16+4096 cycles; dcmreset re-pulses each time; after 300 timeouts fail_cnt stays 255.
REQ-028 In RUN, ext_tog stops -> within 64+3 cycles state=0, ext_ok=0, cnt_inhibit=1.
REQ-029 In RUN, sync_req pulse -> sync_ack on the same cycle state leaves RUN, cnt_reset high exactly 8 cycles, RUN re-entered; sync_req during WAITLOCK -> no ack.
REQ-030 In RUN, sync_req on the same cycle dcm_locked drops -> state=0 and no sync_ack.
REQ-031 reset asserted during WAITLOCK and during ZERO -> state=0 and all outputs at reset values on the next edge.
